// File: rtl/adder_error_monitor.sv
// ============================================================================
// Module      : adder_error_monitor
// Description : Checks samples from an approximate adder against the exact sum
//               and accumulates error statistics over one run.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module adder_error_monitor #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 32,
    parameter int ACC_W = 48
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear,
    input  logic               start,
    input  logic [CNT_W-1:0]   sample_target,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   op_a,
    input  logic [WIDTH-1:0]   op_b,
    input  logic [WIDTH:0]     approx_sum,
    output logic               busy,
    output logic               done,
    output logic [CNT_W-1:0]   stat_samples,
    output logic [CNT_W-1:0]   stat_errors,
    output logic [WIDTH:0]     stat_max_ed,
    output logic [ACC_W-1:0]   stat_sum_ed,
    output logic               stat_sat
);

    localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_target;
    logic [CNT_W-1:0]   r_accepted;
    logic               r_s1_valid;
    logic [WIDTH:0]     r_s1_ed;
    logic               r_done;
    logic [CNT_W-1:0]   r_samples;
    logic [CNT_W-1:0]   r_errors;
    logic [WIDTH:0]     r_max_ed;
    logic [ACC_W-1:0]   r_sum_ed;
    logic               r_sat;

    logic               w_xfer;
    logic               w_last;
    logic [WIDTH:0]     w_exact;
    logic [WIDTH:0]     w_ed;
    logic [ACC_W:0]     w_sum_ext;

    assign w_xfer    = in_valid && (r_state == S_RUN);
    assign w_last    = (r_accepted == (r_target - c_CNT_ONE));
    assign w_exact   = {1'b0, op_a} + {1'b0, op_b};
    assign w_ed      = (w_exact >= approx_sum) ? (w_exact - approx_sum)
                                               : (approx_sum - w_exact);
    // One spare bit catches overflow of the accumulator for clamping.
    assign w_sum_ext = {1'b0, r_sum_ed} + {{(ACC_W-WIDTH){1'b0}}, r_s1_ed};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_target   <= '0;
            r_accepted <= '0;
            r_s1_valid <= 1'b0;
            r_s1_ed    <= '0;
            r_done     <= 1'b0;
            r_samples  <= '0;
            r_errors   <= '0;
            r_max_ed   <= '0;
            r_sum_ed   <= '0;
            r_sat      <= 1'b0;
        end else if (clear) begin
            r_state    <= S_IDLE;
            r_target   <= '0;
            r_accepted <= '0;
            r_s1_valid <= 1'b0;
            r_s1_ed    <= '0;
            r_done     <= 1'b0;
            r_samples  <= '0;
            r_errors   <= '0;
            r_max_ed   <= '0;
            r_sum_ed   <= '0;
            r_sat      <= 1'b0;
        end else begin
            r_done     <= 1'b0;
            r_s1_valid <= w_xfer;
            if (w_xfer) begin
                r_s1_ed <= w_ed;
            end

            if (r_s1_valid) begin
                r_samples <= r_samples + c_CNT_ONE;
                if (r_s1_ed != '0) begin
                    r_errors <= r_errors + c_CNT_ONE;
                end
                if (r_s1_ed > r_max_ed) begin
                    r_max_ed <= r_s1_ed;
                end
                if (w_sum_ext[ACC_W]) begin
                    r_sum_ed <= '1;
                    r_sat    <= 1'b1;
                end else begin
                    r_sum_ed <= w_sum_ext[ACC_W-1:0];
                end
            end

            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_target   <= sample_target;
                        r_accepted <= '0;
                        r_samples  <= '0;
                        r_errors   <= '0;
                        r_max_ed   <= '0;
                        r_sum_ed   <= '0;
                        r_sat      <= 1'b0;
                        if (sample_target == '0) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    if (w_xfer) begin
                        r_accepted <= r_accepted + c_CNT_ONE;
                        if (w_last) begin
                            r_state <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    // Stats register is the final stage, so only S1 can hold data.
                    if (!r_s1_valid) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign in_ready     = (r_state == S_RUN);
    assign busy         = (r_state == S_RUN) || (r_state == S_DRAIN);
    assign done         = r_done;
    assign stat_samples = r_samples;
    assign stat_errors  = r_errors;
    assign stat_max_ed  = r_max_ed;
    assign stat_sum_ed  = r_sum_ed;
    assign stat_sat     = r_sat;

endmodule

`default_nettype wire

// File: tb/tb_adder_error_monitor.sv
// ============================================================================
// Module      : tb_adder_error_monitor
// Description : Scoreboard bench for adder_error_monitor (ACC_W=20 build).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_adder_error_monitor;

    localparam int WIDTH = 16;
    localparam int CNT_W = 32;
    localparam int ACC_W = 20;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               clear = 1'b0;
    logic               start = 1'b0;
    logic [CNT_W-1:0]   sample_target = '0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic [WIDTH-1:0]   op_a = '0;
    logic [WIDTH-1:0]   op_b = '0;
    logic [WIDTH:0]     approx_sum = '0;
    logic               busy;
    logic               done;
    logic [CNT_W-1:0]   stat_samples;
    logic [CNT_W-1:0]   stat_errors;
    logic [WIDTH:0]     stat_max_ed;
    logic [ACC_W-1:0]   stat_sum_ed;
    logic               stat_sat;

    int n_checks = 0;
    int n_err    = 0;
    int done_cnt = 0;
    int xfer_cnt = 0;

    logic [WIDTH:0]     sb_q[$];
    logic [CNT_W-1:0]   m_samples = '0;
    logic [CNT_W-1:0]   m_errors  = '0;
    logic [WIDTH:0]     m_max     = '0;
    logic [ACC_W-1:0]   m_sum     = '0;
    logic               m_sat     = 1'b0;

    adder_error_monitor #(.WIDTH(WIDTH), .CNT_W(CNT_W), .ACC_W(ACC_W)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear), .start(start),
        .sample_target(sample_target), .in_valid(in_valid), .in_ready(in_ready),
        .op_a(op_a), .op_b(op_b), .approx_sum(approx_sum), .busy(busy), .done(done),
        .stat_samples(stat_samples), .stat_errors(stat_errors), .stat_max_ed(stat_max_ed),
        .stat_sum_ed(stat_sum_ed), .stat_sat(stat_sat)
    );

    always #5 clk = ~clk;

    function automatic logic [WIDTH:0] calc_ed(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b,
                                               input logic [WIDTH:0] s);
        logic [WIDTH:0] ex;
        ex = {1'b0, a} + {1'b0, b};
        return (ex > s) ? ex - s : s - ex;
    endfunction

    task automatic model_reset();
        sb_q.delete();
        m_samples = '0;
        m_errors  = '0;
        m_max     = '0;
        m_sum     = '0;
        m_sat     = 1'b0;
        done_cnt  = 0;
        xfer_cnt  = 0;
    endtask

    // Scoreboard: transfers push expected distance; each stats step pops one.
    always @(negedge clk) begin
        if (rst_n) begin
            if (done) done_cnt++;
            if (in_valid && in_ready && !clear) begin
                sb_q.push_back(calc_ed(op_a, op_b, approx_sum));
                xfer_cnt++;
            end
            if (stat_samples != m_samples) begin
                n_checks++;
                if (sb_q.size() == 0) begin
                    n_err++;
                    $display("FAIL sb_underflow stat_samples=%0d expected=%0d", stat_samples, m_samples);
                    m_samples = stat_samples;
                end else begin
                    logic [WIDTH:0] ed;
                    logic [ACC_W:0] t;
                    ed = sb_q.pop_front();
                    m_samples = m_samples + 1;
                    if (ed != 0) m_errors = m_errors + 1;
                    if (ed > m_max) m_max = ed;
                    t = {1'b0, m_sum} + ACC_W'(ed);
                    if (t[ACC_W]) begin
                        m_sum = '1;
                        m_sat = 1'b1;
                    end else begin
                        m_sum = t[ACC_W-1:0];
                    end
                    if (stat_samples !== m_samples || stat_errors !== m_errors ||
                        stat_max_ed !== m_max || stat_sum_ed !== m_sum || stat_sat !== m_sat) begin
                        n_err++;
                        $display("FAIL sb_stats got s=%0d e=%0d max=%h sum=%h sat=%b want s=%0d e=%0d max=%h sum=%h sat=%b",
                                 stat_samples, stat_errors, stat_max_ed, stat_sum_ed, stat_sat,
                                 m_samples, m_errors, m_max, m_sum, m_sat);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // All tasks start and end at 1 time unit after a rising edge.
    task automatic start_run(input logic [CNT_W-1:0] tgt);
        start = 1'b1;
        sample_target = tgt;
        @(posedge clk); #1;
        start = 1'b0;
        model_reset();
    endtask

    task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic [WIDTH:0] s);
        logic rdy;
        bit   ok;
        ok = 0;
        in_valid = 1'b1; op_a = a; op_b = b; approx_sum = s;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk); rdy = in_ready;
            @(posedge clk); #1;
            if (rdy) begin ok = 1; break; end
        end
        in_valid = 1'b0;
        n_checks++;
        if (!ok) begin n_err++; $display("FAIL send_timeout in_ready=%b required=1", in_ready); end
    endtask

    task automatic wait_done(output int lat);
        lat = -1;
        for (int i = 0; i < 20; i++) begin
            if (done) begin lat = i; break; end
            @(posedge clk); #1;
        end
        n_checks++;
        if (lat < 0) begin n_err++; $display("FAIL done_timeout done=%b required=1", done); end
    endtask

    task automatic test_reset();
        #2;
        n_checks++;
        if ({in_ready, busy, done, stat_samples, stat_errors, stat_max_ed, stat_sum_ed, stat_sat} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs ready=%b busy=%b done=%b s=%0d e=%0d max=%h sum=%h sat=%b required all 0",
                     in_ready, busy, done, stat_samples, stat_errors, stat_max_ed, stat_sum_ed, stat_sat);
        end
        #10 rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_exact();
        int lat;
        start_run(3);
        send(16'h1234, 16'h0001, 17'h01235);
        send(16'hFFFF, 16'h0001, 17'h10000);
        send(16'h0000, 16'h0000, 17'h00000);
        wait_done(lat);
        n_checks++;
        if (lat !== 2) begin n_err++; $display("FAIL exact_done_latency got=%0d required=2", lat); end
        repeat (3) @(posedge clk); #1;
        n_checks++;
        if (done_cnt !== 1) begin n_err++; $display("FAIL exact_done_pulses got=%0d required=1", done_cnt); end
        n_checks++;
        if (stat_samples !== 3 || stat_errors !== 0 || stat_max_ed !== 0 || stat_sum_ed !== 0) begin
            n_err++;
            $display("FAIL exact_stats got s=%0d e=%0d max=%h sum=%h required 3 0 0 0",
                     stat_samples, stat_errors, stat_max_ed, stat_sum_ed);
        end
    endtask

    task automatic test_truncated();
        int lat;
        start_run(2);
        send(16'h00FF, 16'h0001, 17'h00000);
        send(16'h0200, 16'h0000, 17'h00000);
        wait_done(lat);
        n_checks++;
        if (stat_samples !== 2 || stat_errors !== 2 || stat_max_ed !== 17'h200 || stat_sum_ed !== 20'h300) begin
            n_err++;
            $display("FAIL trunc_stats got s=%0d e=%0d max=%h sum=%h required 2 2 200 300",
                     stat_samples, stat_errors, stat_max_ed, stat_sum_ed);
        end
    endtask

    task automatic test_handshake();
        bit issued;
        issued = 0;
        start_run(4);
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            op_a = 16'(i * 7); op_b = 16'(i * 3); approx_sum = 17'(i * 10);
            @(posedge clk); #1;
            start = 1'b0;
            if (xfer_cnt == 4 && !issued) begin
                issued = 1;
                start = 1'b1;
                n_checks++;
                if (in_ready !== 1'b0 || busy !== 1'b1) begin
                    n_err++;
                    $display("FAIL hs_after_last in_ready=%b busy=%b required 0 1", in_ready, busy);
                end
            end
        end
        in_valid = 1'b0;
        n_checks++;
        if (xfer_cnt !== 4) begin n_err++; $display("FAIL hs_transfers got=%0d required=4", xfer_cnt); end
        n_checks++;
        if (done_cnt !== 1 || busy !== 1'b0 || stat_samples !== 4 || stat_errors !== 0) begin
            n_err++;
            $display("FAIL hs_drain_start done_cnt=%0d busy=%b s=%0d e=%0d required 1 0 4 0",
                     done_cnt, busy, stat_samples, stat_errors);
        end
    endtask

    task automatic test_saturation();
        int lat;
        start_run(9);
        for (int i = 0; i < 9; i++) send(16'h0000, 16'h0000, 17'h1FFFF);
        wait_done(lat);
        n_checks++;
        if (stat_sum_ed !== 20'hFFFFF || stat_sat !== 1'b1) begin
            n_err++;
            $display("FAIL sat_sum got sum=%h sat=%b required FFFFF 1", stat_sum_ed, stat_sat);
        end
        n_checks++;
        if (stat_errors !== 9 || stat_samples !== 9 || stat_max_ed !== 17'h1FFFF) begin
            n_err++;
            $display("FAIL sat_counts got e=%0d s=%0d max=%h required 9 9 1FFFF",
                     stat_errors, stat_samples, stat_max_ed);
        end
    endtask

    task automatic test_abort();
        start_run(5);
        send(16'h0010, 16'h0000, 17'h00000);
        send(16'h0020, 16'h0000, 17'h00000);
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        model_reset();
        repeat (4) @(posedge clk); #1;
        n_checks++;
        if (busy !== 1'b0 || in_ready !== 1'b0 || done_cnt !== 0 ||
            {stat_samples, stat_errors, stat_max_ed, stat_sum_ed, stat_sat} !== '0) begin
            n_err++;
            $display("FAIL clear_idle busy=%b ready=%b done_cnt=%0d s=%0d e=%0d max=%h sum=%h required idle, 0 stats",
                     busy, in_ready, done_cnt, stat_samples, stat_errors, stat_max_ed, stat_sum_ed);
        end
        start_run(5);
        send(16'h0000, 16'h0000, 17'h00005);
        send(16'h0000, 16'h0000, 17'h00003);
        n_checks++;
        if (stat_samples !== 1 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL rst_prereq s=%0d busy=%b required 1 1", stat_samples, busy);
        end
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if ({in_ready, busy, done, stat_samples, stat_errors, stat_max_ed, stat_sum_ed, stat_sat} !== '0) begin
            n_err++;
            $display("FAIL async_reset ready=%b busy=%b done=%b s=%0d e=%0d max=%h sum=%h sat=%b required all 0",
                     in_ready, busy, done, stat_samples, stat_errors, stat_max_ed, stat_sum_ed, stat_sat);
        end
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        n_checks++;
        if (busy !== 1'b0 || stat_samples !== 0) begin
            n_err++;
            $display("FAIL reset_idle busy=%b s=%0d required 0 0", busy, stat_samples);
        end
    endtask

    task automatic test_zero_target();
        start_run(0);
        n_checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL zero_done done=%b busy=%b required 1 0", done, busy);
        end
        in_valid = 1'b1;
        repeat (5) @(posedge clk); #1;
        in_valid = 1'b0;
        n_checks++;
        if (xfer_cnt !== 0 || done_cnt !== 1 ||
            {stat_samples, stat_errors, stat_max_ed, stat_sum_ed, stat_sat} !== '0) begin
            n_err++;
            $display("FAIL zero_stats xfers=%0d done_cnt=%0d s=%0d e=%0d sum=%h required 0 1 0 0 0",
                     xfer_cnt, done_cnt, stat_samples, stat_errors, stat_sum_ed);
        end
    endtask

    initial begin
        test_reset();
        test_exact();
        test_truncated();
        test_handshake();
        test_saturation();
        test_abort();
        test_zero_target();
        n_checks++;
        if (sb_q.size() !== 0) begin
            n_err++;
            $display("FAIL sb_leftover entries=%0d required=0", sb_q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
